// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared encodings and field limits for the clock mode controller
package clock_pkg;

   localparam int HR_W   = 5;
   localparam int MS_W   = 6;
   localparam int HR_MAX = 23;
   localparam int MS_MAX = 59;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_CLK = 2'b00;
   localparam mode_t MODE_SW  = 2'b01;
   localparam mode_t MODE_TMR = 2'b10;
   localparam mode_t MODE_ALM = 2'b11;

   localparam logic [2:0] ST_RUN      = 3'd0;
   localparam logic [2:0] ST_EDIT_HR  = 3'd1;
   localparam logic [2:0] ST_EDIT_MIN = 3'd2;
   localparam logic [2:0] ST_EDIT_SEC = 3'd3;
   localparam logic [2:0] ST_COMMIT   = 3'd4;

endpackage

// File: rtl/wrap_step.sv
// rtl/wrap_step.sv - combinational +/-1 step of a field that wraps between 0 and MAX
module wrap_step #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic [W-1:0] val,
   input  logic         inc,
   output logic [W-1:0] res
);

   always_comb begin
      res = val;
      if (inc) begin
         res = (val >= W'(MAX)) ? '0 : val + 1'b1;
      end else begin
         res = (val == '0) ? W'(MAX) : val - 1'b1;
      end
   end

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - button-driven mode select, preset registers and time edit FSM
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int HR_MAX    = clock_pkg::HR_MAX,
   parameter int MS_MAX    = clock_pkg::MS_MAX,
   parameter int TIMEOUT_S = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick_1hz,
   input  logic            btn_mode,
   input  logic            btn_set,
   input  logic            btn_up,
   input  logic            btn_down,
   input  logic [HR_W-1:0] cur_hr,
   input  logic [MS_W-1:0] cur_min,
   input  logic [MS_W-1:0] cur_sec,
   output logic [1:0]      mode_sel,
   output logic            edit_act,
   output logic [1:0]      edit_fld,
   output logic [HR_W-1:0] set_hr,
   output logic [MS_W-1:0] set_min,
   output logic [MS_W-1:0] set_sec,
   output logic            load_time,
   output logic [HR_W-1:0] alarm_hr,
   output logic [MS_W-1:0] alarm_min,
   output logic [MS_W-1:0] alarm_sec,
   output logic            alarm_en,
   output logic [HR_W-1:0] timer_hr,
   output logic [MS_W-1:0] timer_min,
   output logic [MS_W-1:0] timer_sec,
   output logic            timer_load,
   output logic            timer_start,
   output logic            sw_run,
   output logic            sw_rst
);

   localparam int TO_W = $clog2(TIMEOUT_S + 1);

   logic [2:0]      state;
   logic [TO_W-1:0] to_cnt;
   logic [HR_W-1:0] hr_step;
   logic [MS_W-1:0] min_step;
   logic [MS_W-1:0] sec_step;

   // up outranks down, so the step direction is simply btn_up
   wrap_step #(.W(HR_W), .MAX(HR_MAX)) u_step_hr (
      .val (set_hr),
      .inc (btn_up),
      .res (hr_step)
   );

   wrap_step #(.W(MS_W), .MAX(MS_MAX)) u_step_min (
      .val (set_min),
      .inc (btn_up),
      .res (min_step)
   );

   wrap_step #(.W(MS_W), .MAX(MS_MAX)) u_step_sec (
      .val (set_sec),
      .inc (btn_up),
      .res (sec_step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         to_cnt      <= '0;
         mode_sel    <= MODE_CLK;
         edit_act    <= 1'b0;
         edit_fld    <= 2'd0;
         set_hr      <= '0;
         set_min     <= '0;
         set_sec     <= '0;
         load_time   <= 1'b0;
         alarm_hr    <= '0;
         alarm_min   <= '0;
         alarm_sec   <= '0;
         alarm_en    <= 1'b0;
         timer_hr    <= '0;
         timer_min   <= '0;
         timer_sec   <= '0;
         timer_load  <= 1'b0;
         timer_start <= 1'b0;
         sw_run      <= 1'b0;
         sw_rst      <= 1'b0;
      end else begin
         load_time   <= 1'b0;
         timer_load  <= 1'b0;
         timer_start <= 1'b0;
         sw_rst      <= 1'b0;

         case (state)
            ST_RUN: begin
               to_cnt <= '0;
               if (btn_mode) begin
                  mode_sel <= mode_sel + 2'd1;
               end else if (btn_set) begin
                  if (mode_sel == MODE_SW) begin
                     sw_run <= ~sw_run;
                  end else begin
                     state    <= ST_EDIT_HR;
                     edit_act <= 1'b1;
                     edit_fld <= 2'd0;
                     case (mode_sel)
                        MODE_CLK: begin
                           set_hr  <= cur_hr;
                           set_min <= cur_min;
                           set_sec <= cur_sec;
                        end
                        MODE_TMR: begin
                           set_hr  <= timer_hr;
                           set_min <= timer_min;
                           set_sec <= timer_sec;
                        end
                        default: begin
                           set_hr  <= alarm_hr;
                           set_min <= alarm_min;
                           set_sec <= alarm_sec;
                        end
                     endcase
                  end
               end else if (btn_up) begin
                  case (mode_sel)
                     MODE_SW:  sw_rst      <= 1'b1;
                     MODE_TMR: timer_start <= 1'b1;
                     MODE_ALM: alarm_en    <= ~alarm_en;
                     default:  ;
                  endcase
               end
            end

            ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
               if (btn_mode) begin
                  state    <= ST_RUN;
                  edit_act <= 1'b0;
                  edit_fld <= 2'd0;
                  to_cnt   <= '0;
               end else if (btn_set) begin
                  to_cnt <= '0;
                  case (state)
                     ST_EDIT_HR: begin
                        state    <= ST_EDIT_MIN;
                        edit_fld <= 2'd1;
                     end
                     ST_EDIT_MIN: begin
                        state    <= ST_EDIT_SEC;
                        edit_fld <= 2'd2;
                     end
                     default: begin
                        // commit side effects land on the same edge as entering COMMIT
                        state    <= ST_COMMIT;
                        edit_act <= 1'b0;
                        case (mode_sel)
                           MODE_CLK: load_time <= 1'b1;
                           MODE_TMR: begin
                              timer_hr   <= set_hr;
                              timer_min  <= set_min;
                              timer_sec  <= set_sec;
                              timer_load <= 1'b1;
                           end
                           MODE_ALM: begin
                              alarm_hr  <= set_hr;
                              alarm_min <= set_min;
                              alarm_sec <= set_sec;
                           end
                           default: ;
                        endcase
                     end
                  endcase
               end else if (btn_up || btn_down) begin
                  to_cnt <= '0;
                  case (state)
                     ST_EDIT_HR:  set_hr  <= hr_step;
                     ST_EDIT_MIN: set_min <= min_step;
                     default:     set_sec <= sec_step;
                  endcase
               end else if (tick_1hz) begin
                  if (to_cnt == TO_W'(TIMEOUT_S - 1)) begin
                     state    <= ST_RUN;
                     edit_act <= 1'b0;
                     edit_fld <= 2'd0;
                     to_cnt   <= '0;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end

            ST_COMMIT: begin
               state    <= ST_RUN;
               edit_fld <= 2'd0;
            end

            default: begin
               state    <= ST_RUN;
               edit_act <= 1'b0;
               edit_fld <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz, btn_mode, btn_set, btn_up, btn_down;
   logic [4:0] cur_hr;
   logic [5:0] cur_min, cur_sec;
   logic [1:0] mode_sel, edit_fld;
   logic       edit_act, load_time, alarm_en, timer_load, timer_start, sw_run, sw_rst;
   logic [4:0] set_hr, alarm_hr, timer_hr;
   logic [5:0] set_min, set_sec, alarm_min, alarm_sec, timer_min, timer_sec;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [3:0] B_MODE = 4'b1000;
   localparam logic [3:0] B_SET  = 4'b0100;
   localparam logic [3:0] B_UP   = 4'b0010;
   localparam logic [3:0] B_DN   = 4'b0001;

   always #5 clk = ~clk;

   clock_mode_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .tick_1hz    (tick_1hz),
      .btn_mode    (btn_mode),
      .btn_set     (btn_set),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .cur_hr      (cur_hr),
      .cur_min     (cur_min),
      .cur_sec     (cur_sec),
      .mode_sel    (mode_sel),
      .edit_act    (edit_act),
      .edit_fld    (edit_fld),
      .set_hr      (set_hr),
      .set_min     (set_min),
      .set_sec     (set_sec),
      .load_time   (load_time),
      .alarm_hr    (alarm_hr),
      .alarm_min   (alarm_min),
      .alarm_sec   (alarm_sec),
      .alarm_en    (alarm_en),
      .timer_hr    (timer_hr),
      .timer_min   (timer_min),
      .timer_sec   (timer_sec),
      .timer_load  (timer_load),
      .timer_start (timer_start),
      .sw_run      (sw_run),
      .sw_rst      (sw_rst)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] b);
      @(negedge clk);
      {btn_mode, btn_set, btn_up, btn_down} = b;
      @(posedge clk);
      #1;
      {btn_mode, btn_set, btn_up, btn_down} = 4'b0000;
   endtask

   task automatic press_n(input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) press(b);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick_1hz = 1'b1;
         @(posedge clk);
         #1;
         tick_1hz = 1'b0;
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      {tick_1hz, btn_mode, btn_set, btn_up, btn_down} = 5'b0;
      cur_hr = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mode", 32'(mode_sel), 0);
      check("rst_edit", 32'(edit_act), 0);
      check("rst_sw_run", 32'(sw_run), 0);
      check("rst_alarm_en", 32'(alarm_en), 0);
      check("rst_load", 32'(load_time), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 1; i <= 4; i++) begin
         press(B_MODE);
         check("mode_step", 32'(mode_sel), 32'(i % 4));
      end

      // clock edit with hour wrap and minute down
      press(B_SET);
      check("clk_edit_act", 32'(edit_act), 1);
      check("clk_fld_hr", 32'(edit_fld), 0);
      check("clk_pre_hr", 32'(set_hr), 12);
      check("clk_pre_min", 32'(set_min), 34);
      cur_hr = 5'd5;
      press_n(B_UP, 11);
      check("clk_hr_max", 32'(set_hr), 23);
      press(B_UP);
      check("clk_hr_wrap", 32'(set_hr), 0);
      press(B_SET);
      check("clk_fld_min", 32'(edit_fld), 1);
      press(B_DN);
      check("clk_min_dn", 32'(set_min), 33);
      press(B_SET);
      check("clk_fld_sec", 32'(edit_fld), 2);
      press(B_SET);
      check("clk_load", 32'(load_time), 1);
      check("clk_commit_act", 32'(edit_act), 0);
      check("clk_set_hr", 32'(set_hr), 0);
      check("clk_set_min", 32'(set_min), 33);
      check("clk_set_sec", 32'(set_sec), 56);
      idle();
      check("clk_load_1cyc", 32'(load_time), 0);
      press(B_MODE);
      check("clk_back_run", 32'(mode_sel), 1);
      press_n(B_MODE, 2);
      check("alm_mode", 32'(mode_sel), 3);

      // alarm edit to 06:30:00
      press(B_SET);
      check("alm_pre_min", 32'(set_min), 0);
      press_n(B_UP, 6);
      press(B_SET);
      press_n(B_UP, 30);
      press(B_SET);
      press(B_SET);
      check("alm_no_load", 32'(load_time), 0);
      check("alm_hr", 32'(alarm_hr), 6);
      check("alm_min", 32'(alarm_min), 30);
      check("alm_sec", 32'(alarm_sec), 0);
      press(B_UP);
      check("alm_commit_drop", 32'(alarm_en), 0);
      press(B_UP);
      check("alm_en", 32'(alarm_en), 1);

      // timer edit: seconds 0 down to 59
      press_n(B_MODE, 3);
      check("tmr_mode", 32'(mode_sel), 2);
      press(B_SET);
      check("tmr_pre_min", 32'(set_min), 0);
      press_n(B_SET, 2);
      press(B_DN);
      check("tmr_sec_wrap", 32'(set_sec), 59);
      press(B_SET);
      check("tmr_load", 32'(timer_load), 1);
      check("tmr_sec", 32'(timer_sec), 59);
      check("tmr_hr", 32'(timer_hr), 0);
      check("tmr_no_load_time", 32'(load_time), 0);
      idle();
      check("tmr_load_1cyc", 32'(timer_load), 0);
      press(B_UP);
      check("tmr_start", 32'(timer_start), 1);
      idle();
      check("tmr_start_1cyc", 32'(timer_start), 0);

      // timeout abort, with a press restarting the count
      press(B_SET);
      press(B_UP);
      check("to_hr_step", 32'(set_hr), 1);
      tick(5);
      press(B_UP);
      tick(9);
      check("to_still_edit", 32'(edit_act), 1);
      tick(1);
      check("to_abort", 32'(edit_act), 0);
      check("to_timer_hr", 32'(timer_hr), 0);
      check("to_mode", 32'(mode_sel), 2);
      press(B_SET);
      check("mab_enter", 32'(edit_act), 1);
      press(B_MODE);
      check("mab_abort", 32'(edit_act), 0);
      check("mab_mode_kept", 32'(mode_sel), 2);
      check("mab_timer_sec", 32'(timer_sec), 59);

      // stopwatch controls and button priority
      press_n(B_MODE, 3);
      check("sw_mode", 32'(mode_sel), 1);
      press(B_SET);
      check("sw_run_on", 32'(sw_run), 1);
      press(B_SET);
      check("sw_run_off", 32'(sw_run), 0);
      press(B_UP);
      check("sw_rst", 32'(sw_rst), 1);
      check("sw_rst_run", 32'(sw_run), 0);
      idle();
      check("sw_rst_1cyc", 32'(sw_rst), 0);
      press(B_MODE | B_SET);
      check("prio_mode", 32'(mode_sel), 2);
      check("prio_no_set", 32'(sw_run), 0);
      check("prio_no_edit", 32'(edit_act), 0);

      // asynchronous reset in EDIT_MIN
      press_n(B_SET, 2);
      check("ar_fld_min", 32'(edit_fld), 1);
      press(B_UP);
      check("ar_min_step", 32'(set_min), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ar_edit", 32'(edit_act), 0);
      check("ar_fld", 32'(edit_fld), 0);
      check("ar_mode", 32'(mode_sel), 0);
      check("ar_set_min", 32'(set_min), 0);
      check("ar_timer_sec", 32'(timer_sec), 0);
      check("ar_alarm_hr", 32'(alarm_hr), 0);
      check("ar_alarm_en", 32'(alarm_en), 0);
      idle();
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
